ram_64x32bit_arb: RTL and testbench

RAM_64X32BIT_ARB -- requirements
Module: ram_64x32bit_arb

---
 rtl/ram_64x32bit_arb.sv | 104 ++++++++++
 tb/tb_ram_64x32bit_arb.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_64x32bit_arb.sv
// Two-port arbiter in front of a single-port RAM: IDLE -> SERVE -> RESP per access.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority (A wins); default is round-robin.
module ram_64x32bit_arb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              Mem_Write,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] M_W_Data,
  input  logic [DATA_W-1:0] M_R_Data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;

  state_t state;
  logic   gnt_b;
  logic   sel_b;

`ifdef RAM_ARB_FIXED_PRIO_EN
  always_comb begin
    sel_b = ~a_req;
  end
`else
  logic last_b;

  // On contention grant whichever port was not served last; a lone request always wins.
  always_comb begin
    sel_b = (a_req & b_req) ? ~last_b : b_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b <= 1'b1;
    end else if (state == IDLE && (a_req | b_req)) begin
      last_b <= sel_b;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt_b     <= 1'b0;
      Mem_Write <= 1'b0;
      Mem_Addr  <= '0;
      M_W_Data  <= '0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (a_req | b_req) begin
            state     <= SERVE;
            busy      <= 1'b1;
            gnt_b     <= sel_b;
            Mem_Write <= sel_b ? b_we    : a_we;
            Mem_Addr  <= sel_b ? b_addr  : a_addr;
            M_W_Data  <= sel_b ? b_wdata : a_wdata;
          end
        end
        // SERVE: Mem_Write still holds the granted direction, so it selects read capture.
        SERVE: begin
          state     <= RESP;
          Mem_Write <= 1'b0;
          if (gnt_b) begin
            b_ack <= 1'b1;
            if (!Mem_Write) b_rdata <= M_R_Data;
          end else begin
            a_ack <= 1'b1;
            if (!Mem_Write) a_rdata <= M_R_Data;
          end
        end
        RESP: begin
          state <= IDLE;
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_64x32bit_arb.sv
// Self-checking bench for ram_64x32bit_arb: directed table, held-request and reset corners,
// then randomized transactions against a transaction-level reference model.
module tb_ram_64x32bit_arb;

  logic        clk;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [7:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        a_ack, b_ack;
  logic [31:0] a_rdata, b_rdata;
  logic        Mem_Write;
  logic [7:0]  Mem_Addr;
  logic [31:0] M_W_Data;
  logic [31:0] M_R_Data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  ram_64x32bit_arb dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .Mem_Write(Mem_Write), .Mem_Addr(Mem_Addr), .M_W_Data(M_W_Data),
    .M_R_Data(M_R_Data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM attached to the memory port: combinational read, write on rising edge.
  logic [31:0] mem [256];
  logic        ram_clr;
  assign M_R_Data = mem[Mem_Addr];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (Mem_Write) begin
      mem[Mem_Addr] <= M_W_Data;
    end
  end

  // Reference model state
  logic [31:0] ref_mem [256];
  logic        ref_last_b;
  logic [31:0] exp_ardata, exp_brdata;

  typedef struct {
    logic        ar, br, aw, bw;
    logic [7:0]  aa, ba;
    logic [31:0] ad, bd;
    logic        exp_gb;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One access from IDLE; caller is at a falling edge with the DUT idle.
  task automatic run_txn(input logic ar, input logic br, input logic aw, input logic bw,
                         input logic [7:0] aa, input logic [7:0] ba,
                         input logic [31:0] ad, input logic [31:0] bd,
                         output logic g_b, output logic [31:0] rd);
    logic        we;
    logic [7:0]  ad_sel;
    logic [31:0] wd_sel;
    a_req = ar; b_req = br; a_we = aw; b_we = bw;
    a_addr = aa; b_addr = ba; a_wdata = ad; b_wdata = bd;
    g_b = 1'b0;
    rd  = 32'h0;
    if (!ar && !br) begin
      @(negedge clk);
      chk("idle_busy", {31'b0, busy}, 32'h0);
      chk("idle_acks", {30'b0, a_ack, b_ack}, 32'h0);
      return;
    end
`ifdef RAM_ARB_FIXED_PRIO_EN
    g_b = !ar;
`else
    g_b = (ar && br) ? !ref_last_b : br;
`endif
    ref_last_b = g_b;
    we     = g_b ? bw : aw;
    ad_sel = g_b ? ba : aa;
    wd_sel = g_b ? bd : ad;
    @(negedge clk);
    chk("serve_we",   {31'b0, Mem_Write}, {31'b0, we});
    chk("serve_addr", {24'b0, Mem_Addr}, {24'b0, ad_sel});
    chk("serve_wd",   M_W_Data, wd_sel);
    chk("serve_busy", {31'b0, busy}, 32'h1);
    chk("serve_acks", {30'b0, a_ack, b_ack}, 32'h0);
    if (we) ref_mem[ad_sel] = wd_sel;
    else if (g_b) exp_brdata = ref_mem[ad_sel];
    else exp_ardata = ref_mem[ad_sel];
    @(negedge clk);
    chk("resp_acks",  {30'b0, a_ack, b_ack}, {30'b0, !g_b, g_b});
    chk("resp_ardata", a_rdata, exp_ardata);
    chk("resp_brdata", b_rdata, exp_brdata);
    chk("resp_we",    {31'b0, Mem_Write}, 32'h0);
    chk("resp_addr",  {24'b0, Mem_Addr}, {24'b0, ad_sel});
    rd = g_b ? b_rdata : a_rdata;
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    chk("post_busy", {31'b0, busy}, 32'h0);
    chk("post_acks", {30'b0, a_ack, b_ack}, 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic        g_b, ea, eb;
    logic [31:0] rd;

    rst_n = 1'b0; ram_clr = 1'b1;
    a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    ref_last_b = 1'b1; exp_ardata = 0; exp_brdata = 0;

    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 32'hAAAAAAAA, 32'h0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0, 32'h0, 1'b0, 32'hAAAAAAAA};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h04, 32'h0, 32'h12345678, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h04, 8'h00, 32'h0, 32'h0, 1'b0, 32'h12345678};
`ifdef RAM_ARB_FIXED_PRIO_EN
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h04, 32'h0, 32'h0, 1'b0, 32'hAAAAAAAA};
`else
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h04, 32'h0, 32'h0, 1'b1, 32'h12345678};
`endif
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h04, 32'h0, 32'h0, 1'b1, 32'h12345678};

    repeat (2) @(negedge clk);
    chk("rst_we",     {31'b0, Mem_Write}, 32'h0);
    chk("rst_addr",   {24'b0, Mem_Addr}, 32'h0);
    chk("rst_wd",     M_W_Data, 32'h0);
    chk("rst_acks",   {30'b0, a_ack, b_ack}, 32'h0);
    chk("rst_ardata", a_rdata, 32'h0);
    chk("rst_brdata", b_rdata, 32'h0);
    chk("rst_busy",   {31'b0, busy}, 32'h0);
    ram_clr = 1'b0;
    rst_n = 1'b1;

    // Directed table
    for (int v = 0; v < 6; v++) begin
      run_txn(vecs[v].ar, vecs[v].br, vecs[v].aw, vecs[v].bw, vecs[v].aa, vecs[v].ba,
              vecs[v].ad, vecs[v].bd, g_b, rd);
      chk($sformatf("vec%0d_grant", v), {31'b0, g_b}, {31'b0, vecs[v].exp_gb});
      chk($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rd);
    end

    // Reset asserted in SERVE of a port B write aborts the access
    b_req = 1; b_we = 1; b_addr = 8'h04; b_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("abort_we_before", {31'b0, Mem_Write}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_we",     {31'b0, Mem_Write}, 32'h0);
    chk("abort_addr",   {24'b0, Mem_Addr}, 32'h0);
    chk("abort_wd",     M_W_Data, 32'h0);
    chk("abort_acks",   {30'b0, a_ack, b_ack}, 32'h0);
    chk("abort_rdata",  a_rdata | b_rdata, 32'h0);
    chk("abort_busy",   {31'b0, busy}, 32'h0);
    b_req = 0; b_we = 0;
    @(negedge clk);
    rst_n = 1'b1;
    ref_last_b = 1'b1; exp_ardata = 0; exp_brdata = 0;
    @(negedge clk);
    chk("abort_no_ack", {30'b0, a_ack, b_ack}, 32'h0);
    chk("abort_idle",   {31'b0, busy}, 32'h0);

    // Both ports held reading: acks every third cycle, first on A
    a_req = 1; b_req = 1; a_we = 0; b_we = 0; a_addr = 8'h00; b_addr = 8'h04;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      ea = 0; eb = 0;
      if (k == 14) eb = 1;
      else if (k % 3 == 2) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
        ea = 1;
`else
        if (((k / 3) % 2) == 1) eb = 1; else ea = 1;
`endif
      end
      chk($sformatf("held_k%0d_acks", k), {30'b0, a_ack, b_ack}, {30'b0, ea, eb});
      if (k == 11) a_req = 0;
      if (k == 14) begin
        b_req = 0;
        chk("held_brdata", b_rdata, ref_mem[8'h04]);
      end
    end
    chk("held_ardata", a_rdata, ref_mem[8'h00]);
    exp_ardata = ref_mem[8'h00];
    exp_brdata = ref_mem[8'h04];
    ref_last_b = 1'b1;

    // Randomized transactions
    for (int n = 0; n < 60; n++) begin
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
              $urandom, $urandom, g_b, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
